// File: rtl/rom_word_fetcher.sv
// Fetches req_len consecutive 32-bit big-endian words from a byte-wide ROM, four byte reads per word.
// First rd_vld to word_vld is 5 cycles; each word is held in HOLD until word_rdy, and no reads are issued meanwhile.
module rom_word_fetcher #(
  parameter int ADDR_WD    = 8,
  parameter int DATA_DEPTH = 124
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [ADDR_WD-3:0] req_base,
  input  logic [ADDR_WD-3:0] req_len,
  output logic               rd_vld,
  output logic [ADDR_WD-1:0] rd_addr,
  input  logic [7:0]         rd_data,
  input  logic               rd_data_out_vld,
  output logic               word_vld,
  input  logic               word_rdy,
  output logic [31:0]        word_data,
  output logic               word_last,
  output logic               busy,
  output logic               err
);

  localparam int WW = ADDR_WD - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   word_q, word_d;
  logic [WW-1:0]   rem_q, rem_d;
  logic [1:0]      iss_cnt_q, iss_cnt_d;
  logic [2:0]      rx_cnt_q, rx_cnt_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;

  logic [ADDR_WD-1:0] word_end;
  logic [ADDR_WD+1:0] byte_end;
  logic               req_bad;
  logic               byte_take;

  // One byte past the last requested byte; the sum cannot overflow ADDR_WD bits.
  assign word_end = {2'b00, req_base} + {2'b00, req_len};
  assign byte_end = {word_end, 2'b00};
  assign req_bad  = (req_len == '0) || (byte_end > (ADDR_WD+2)'(DATA_DEPTH));

  // Only the first four returned bytes of a word are used; anything else is dropped.
  assign byte_take = rd_data_out_vld && ((state_q == ISSUE) || (state_q == DRAIN)) && !rx_cnt_q[2];

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    rem_d     = rem_q;
    iss_cnt_d = iss_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    data_d    = data_q;
    err_d     = 1'b0;

    if (byte_take) begin
      rx_cnt_d = rx_cnt_q + 3'd1;
      case (rx_cnt_q[1:0])
        2'd0:    data_d[31:24] = rd_data;
        2'd1:    data_d[23:16] = rd_data;
        2'd2:    data_d[15:8]  = rd_data;
        default: data_d[7:0]   = rd_data;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (req_vld) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d   = ISSUE;
            word_d    = req_base;
            rem_d     = req_len;
            iss_cnt_d = 2'd0;
            rx_cnt_d  = 3'd0;
          end
        end
      end
      ISSUE: begin
        iss_cnt_d = iss_cnt_q + 2'd1;
        if (iss_cnt_q == 2'd3) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rx_cnt_d[2]) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (word_rdy) begin
          if (rem_q == WW'(1)) begin
            state_d = IDLE;
          end else begin
            state_d   = ISSUE;
            word_d    = word_q + WW'(1);
            rem_d     = rem_q - WW'(1);
            iss_cnt_d = 2'd0;
            rx_cnt_d  = 3'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      rem_q     <= '0;
      iss_cnt_q <= 2'd0;
      rx_cnt_q  <= 3'd0;
      data_q    <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      rem_q     <= rem_d;
      iss_cnt_q <= iss_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign req_rdy   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rd_vld    = (state_q == ISSUE);
  // 4*word + byte offset is a plain concatenation since the offset is below 4.
  assign rd_addr   = rd_vld ? {word_q, iss_cnt_q} : '0;
  assign word_vld  = (state_q == HOLD);
  assign word_data = data_q;
  assign word_last = word_vld && (rem_q == WW'(1));
  assign err       = err_q;

endmodule
